// File: rtl/sdac_pkg.sv
// Shared types and constants for the slow-DAC update scheduler.
package sdac_pkg;

  localparam int N_CH_PER_CHIP = 8;
  localparam int N_CHIPS       = 2;
  localparam int N_CH          = N_CH_PER_CHIP * N_CHIPS;
  localparam logic [15:0] CODE_OFFSET = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        rsvd;
    logic [2:0]  ch;
    logic [15:0] code;
  } sdac_frame_t;

  // Two's complement sample to the DAC's offset-binary code.
  function automatic logic [15:0] to_offset_binary(input logic [15:0] s);
    return s ^ CODE_OFFSET;
  endfunction

endpackage

// File: rtl/sdac_update_scheduler_if.sv
// Frame handshake between the update scheduler and the SPI shifter.
interface sdac_update_scheduler_if;

  logic                 valid;
  logic                 ready;
  logic                 chip;
  sdac_pkg::sdac_frame_t word;

  modport master (output valid, chip, word, input ready);
  modport slave  (input valid, chip, word, output ready);

endinterface

// File: rtl/sdac_rr_pick8.sv
// Combinational 8-way round-robin picker: first request strictly after ptr, wrapping.
module sdac_rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx
);

  logic [2:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    cand      = '0;
    // k = 8 wraps back to ptr itself, so the last-served channel is considered last.
    for (int k = 1; k <= 8; k++) begin
      cand = ptr + 3'(k);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sdac_update_scheduler.sv
// Latches channel samples, coalesces writes, and issues one DAC frame at a time,
// alternating chips with per-chip round-robin and periodic refresh.
//
// state | meaning
// IDLE  | waiting for enable and a pending channel; grant happens on leaving
// SEND  | frame presented, waiting for frm.ready
// GAP   | chip-select high time after an accepted frame
module sdac_update_scheduler
  import sdac_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned REFRESH_PERIOD = 100000,
  parameter logic [3:0]  CMD            = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  refresh_en,
  input  logic [N_CH-1:0][15:0] sample,
  input  logic [N_CH-1:0]       sample_valid,
  sdac_update_scheduler_if.master frm,
  output logic                  busy,
  output logic [N_CH-1:0]       overrun,
  input  logic                  overrun_clr
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = $clog2(REFRESH_PERIOD);

  state_t                state, state_nxt;
  logic [GW-1:0]         gap_cnt;
  logic [RW-1:0]         ref_cnt;
  logic [N_CH-1:0]       pending;
  logic [N_CH-1:0][15:0] shadow;
  logic [1:0][2:0]       rr_ptr;
  logic                  last_chip;

  logic [1:0]            gnt_ok;
  logic [1:0][2:0]       gnt_idx;
  logic                  sel_chip;
  logic [2:0]            sel_ch;
  logic [3:0]            sel_idx;
  logic                  grant;
  logic                  hs;
  logic                  refresh_hit;
  logic [N_CH-1:0]       grant_vec;
  sdac_frame_t           next_frame;

  sdac_rr_pick8 u_pick_chip0 (
    .req      (pending[7:0]),
    .ptr      (rr_ptr[0]),
    .gnt_valid(gnt_ok[0]),
    .gnt_idx  (gnt_idx[0])
  );

  sdac_rr_pick8 u_pick_chip1 (
    .req      (pending[15:8]),
    .ptr      (rr_ptr[1]),
    .gnt_valid(gnt_ok[1]),
    .gnt_idx  (gnt_idx[1])
  );

  always_comb begin
    sel_chip = ~last_chip;
    if (!gnt_ok[sel_chip]) sel_chip = last_chip;
    sel_ch  = gnt_idx[sel_chip];
    sel_idx = {sel_chip, sel_ch};
  end

  // Frame reads the shadow before this cycle's capture, so a colliding strobe lands in the next frame.
  always_comb begin
    next_frame.cmd  = CMD;
    next_frame.rsvd = 1'b0;
    next_frame.ch   = sel_ch;
    next_frame.code = to_offset_binary(shadow[sel_idx]);
  end

  assign hs          = frm.valid && frm.ready;
  assign refresh_hit = refresh_en && (ref_cnt == RW'(REFRESH_PERIOD - 1));
  assign grant_vec   = N_CH'(grant) << sel_idx;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && (|pending)) begin
          grant     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      shadow    <= '0;
      overrun   <= '0;
      rr_ptr    <= {3'd7, 3'd7};
      last_chip <= 1'b1;
      gap_cnt   <= '0;
      ref_cnt   <= '0;
      frm.valid <= 1'b0;
      frm.chip  <= 1'b0;
      frm.word  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sample_valid[i]) shadow[i] <= sample[i];
      end
      // Refresh re-arms everything and wins over the grant's clear; strobes never lose.
      pending <= (pending & ~grant_vec) | sample_valid | {N_CH{refresh_hit}};
      overrun <= (overrun & ~{N_CH{overrun_clr}}) | (sample_valid & pending & ~grant_vec);

      if (grant) begin
        frm.valid <= 1'b1;
        frm.chip  <= sel_chip;
        frm.word  <= next_frame;
      end else if (hs) begin
        frm.valid <= 1'b0;
      end

      if (hs) begin
        rr_ptr[frm.chip] <= frm.word.ch;
        last_chip        <= frm.chip;
        gap_cnt          <= GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      if (!refresh_en || refresh_hit) ref_cnt <= '0;
      else                            ref_cnt <= ref_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdac_update_scheduler.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_sdac_update_scheduler;
  import sdac_pkg::*;

  localparam int         GAP   = 4;
  localparam int         REF_P = 50;
  localparam logic [3:0] CMDV  = 4'b0011;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  enable = 1'b0;
  logic                  refresh_en = 1'b0;
  logic [N_CH-1:0][15:0] sample = '0;
  logic [N_CH-1:0]       sample_valid = '0;
  logic                  busy;
  logic [N_CH-1:0]       overrun;
  logic                  overrun_clr = 1'b0;

  sdac_update_scheduler_if frm ();

  sdac_update_scheduler #(
    .GAP_CYCLES    (GAP),
    .REFRESH_PERIOD(REF_P),
    .CMD           (CMDV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .refresh_en  (refresh_en),
    .sample      (sample),
    .sample_valid(sample_valid),
    .frm         (frm),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pend [N_CH];
  logic [15:0] m_shadow [N_CH];
  logic [15:0] m_ovr;
  int          m_ptr [2];
  int          m_last;
  bit          m_vld;
  int          m_gap;
  int          m_chip, m_ch;
  logic [23:0] m_word;
  int          m_rrun;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_pend[i] = 0;
      m_shadow[i] = '0;
    end
    m_ovr = '0; m_ptr[0] = 7; m_ptr[1] = 7; m_last = 1;
    m_vld = 0; m_gap = 0; m_chip = 0; m_ch = 0; m_word = '0; m_rrun = 0;
  endtask

  task automatic model_step();
    bit any [2];
    bit grant = 0;
    bit hs, ref_hit, idle;
    int gc = 0, gch = 0, gi = 0;
    logic [15:0] new_ovr;
    any[0] = 0; any[1] = 0;
    for (int i = 0; i < N_CH; i++) if (m_pend[i]) any[i / 8] = 1;
    idle    = !m_vld && (m_gap == 0);
    hs      = m_vld && frm.ready;
    ref_hit = refresh_en && ((m_rrun % REF_P) == REF_P - 1);
    if (idle && enable && (any[0] || any[1])) begin
      gc = any[1 - m_last] ? 1 - m_last : m_last;
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_ptr[gc] + k) % 8;
        if (m_pend[gc * 8 + c]) begin
          gch = c;
          break;
        end
      end
      gi = gc * 8 + gch;
      grant = 1;
    end
    new_ovr = overrun_clr ? 16'h0 : m_ovr;
    for (int i = 0; i < N_CH; i++)
      if (sample_valid[i] && m_pend[i] && !(grant && gi == i)) new_ovr[i] = 1'b1;
    m_ovr = new_ovr;
    if (grant) begin
      m_word = {CMDV, 1'b0, 3'(gch), m_shadow[gi] ^ 16'h8000};
      m_chip = gc; m_ch = gch; m_vld = 1;
      m_pend[gi] = 0;
    end
    for (int i = 0; i < N_CH; i++)
      if (sample_valid[i]) begin
        m_pend[i] = 1;
        m_shadow[i] = sample[i];
      end
    if (ref_hit) for (int i = 0; i < N_CH; i++) m_pend[i] = 1;
    if (hs) begin
      m_vld = 0; m_ptr[m_chip] = m_ch; m_last = m_chip; m_gap = GAP;
    end else if (m_gap > 0) begin
      m_gap--;
    end
    if (refresh_en) m_rrun++;
    else m_rrun = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("frm_valid", 32'(frm.valid), 32'(m_vld));
    chk("busy", 32'(busy), 32'(m_vld || m_gap > 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (m_vld) begin
      chk("frm_chip", 32'(frm.chip), 32'(m_chip));
      chk("frm_word", 32'(frm.word), 32'(m_word));
    end
  end

  // Accepted-frame log and valid activity counter taken from the DUT.
  logic [24:0] dut_q [$];
  int valid_seen = 0;
  always @(negedge clk) begin
    if (rst_n && frm.valid) valid_seen++;
    if (rst_n && frm.valid && frm.ready) dut_q.push_back({frm.chip, frm.word});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 0; refresh_en = 0; sample_valid = '0; overrun_clr = 0; frm.ready = 0;
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    dut_q.delete();
  endtask

  initial begin
    frm.ready = 1'b0;
    do_reset();
    chk("reset_valid", 32'(frm.valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);

    // Single write: latency two clocks, then GAP of four.
    frm.ready = 1; enable = 1;
    sample[3] = 16'h1234; sample_valid = 16'h0008;
    tick();
    sample_valid = '0;
    chk("single_not_yet", 32'(frm.valid), 32'h0);
    tick();
    chk("single_valid", 32'(frm.valid), 32'h1);
    chk("single_chip", 32'(frm.chip), 32'h0);
    chk("single_word", 32'(frm.word), 32'h339234);
    tick();
    chk("single_accepted", 32'(frm.valid), 32'h0);
    repeat (3) tick();
    chk("single_gap_busy", 32'(busy), 32'h1);
    tick();
    chk("single_gap_done", 32'(busy), 32'h0);

    // Coalescing and overrun.
    do_reset();
    frm.ready = 1;
    sample[5] = 16'h0001; sample_valid = 16'h0020;
    tick();
    sample[5] = 16'h0002;
    tick();
    sample_valid = '0;
    tick();
    chk("coalesce_overrun", 32'(overrun), 32'h0020);
    enable = 1;
    repeat (14) tick();
    chk("coalesce_count", 32'(dut_q.size()), 32'h1);
    if (dut_q.size() > 0) chk("coalesce_word", 32'(dut_q[0]), 32'h0358002);
    overrun_clr = 1;
    tick();
    overrun_clr = 0;
    chk("overrun_clr", 32'(overrun), 32'h0);

    // Chip alternation and round-robin.
    do_reset();
    frm.ready = 1;
    sample[0] = 16'h0100; sample[2] = 16'h0200; sample[9] = 16'h0900; sample[15] = 16'h0F00;
    sample_valid = 16'h8205;
    tick();
    sample_valid = '0; enable = 1;
    repeat (30) tick();
    chk("rr_count", 32'(dut_q.size()), 32'h4);
    if (dut_q.size() == 4) begin
      logic [24:0] f;
      f = dut_q[0]; chk("rr_0", {28'h0, f[24], f[18:16]}, 32'h0);
      f = dut_q[1]; chk("rr_1", {28'h0, f[24], f[18:16]}, 32'h9);
      f = dut_q[2]; chk("rr_2", {28'h0, f[24], f[18:16]}, 32'h2);
      f = dut_q[3]; chk("rr_3", {28'h0, f[24], f[18:16]}, 32'hF);
    end

    // Backpressure plus grant/capture collision.
    do_reset();
    enable = 1;
    sample[4] = 16'h1111; sample_valid = 16'h0010;
    tick();
    sample[4] = 16'h7FFF;
    tick();
    sample_valid = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_word_stable", 32'(frm.word), 32'h349111);
      tick();
    end
    frm.ready = 1;
    repeat (20) tick();
    chk("coll_count", 32'(dut_q.size()), 32'h2);
    if (dut_q.size() == 2) begin
      chk("coll_first", 32'(dut_q[0]), 32'h0349111);
      chk("coll_second", 32'(dut_q[1]), 32'h034FFFF);
    end
    chk("coll_no_overrun", 32'(overrun), 32'h0);

    // Refresh re-sends the held shadow values.
    do_reset();
    for (int i = 0; i < N_CH; i++) sample[i] = 16'(i * 16'h0111);
    sample_valid = 16'hFFFF;
    tick();
    sample_valid = '0; enable = 1; frm.ready = 1;
    repeat (120) tick();
    chk("refresh_drain", 32'(dut_q.size()), 32'd16);
    dut_q.delete();
    refresh_en = 1;
    repeat (300) tick();
    chk("refresh_some", 32'(dut_q.size() >= 16), 32'h1);
    begin
      logic [15:0] seen;
      bit code_ok;
      seen = '0; code_ok = 1;
      for (int j = 0; j < dut_q.size(); j++) begin
        logic [24:0] f;
        int ch;
        f = dut_q[j];
        ch = f[24] * 8 + f[18:16];
        if (j < 16) seen[ch] = 1'b1;
        if (f[15:0] != (16'(ch * 16'h0111) ^ 16'h8000)) code_ok = 0;
      end
      chk("refresh_all16", 32'(seen), 32'hFFFF);
      chk("refresh_codes", 32'(code_ok), 32'h1);
    end
    chk("refresh_no_overrun", 32'(overrun), 32'h0);
    refresh_en = 0;

    // Reset while a frame is outstanding.
    do_reset();
    enable = 1;
    sample[1] = 16'h4444; sample_valid = 16'h0002;
    tick();
    sample_valid = '0;
    begin
      int budget = 10;
      while (!frm.valid && budget > 0) begin
        tick();
        budget--;
      end
      chk("rst_send_reached", 32'(frm.valid), 32'h1);
    end
    rst_n = 0;
    #1;
    chk("rst_async_valid", 32'(frm.valid), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1; frm.ready = 1; enable = 1;
    valid_seen = 0;
    repeat (20) tick();
    chk("rst_no_frame", 32'(valid_seen), 32'h0);

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      enable      = ($urandom_range(0, 9) != 0);
      frm.ready   = ($urandom_range(0, 9) < 7);
      overrun_clr = ($urandom_range(0, 49) == 0);
      if (cyc % 500 == 0) refresh_en = $urandom_range(0, 1);
      for (int i = 0; i < N_CH; i++) begin
        sample_valid[i] = ($urandom_range(0, 39) == 0);
        sample[i] = 16'($urandom);
      end
      tick();
    end
    sample_valid = '0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
